// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// The optional output register is selected with the REGFILE_WB_PIPE_EN macro.
package regfile_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int LOG2_REGISTERS = 5;
    localparam int NUM_REQ        = 4;
    localparam int LOG2_REQ       = 2;
    localparam int CNT_WIDTH      = 16;

    typedef logic [LOG2_REGISTERS-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     reg_data_t;
    typedef logic [LOG2_REQ-1:0]       req_idx_t;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or after rr_ptr,
// and advances rr_ptr past the winner whenever a grant is issued.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = NUM_REQ,
    parameter int IDX_W = LOG2_REQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] cand_s;
    logic [IDX_W-1:0] idx_s;
    logic             hit_s;
    logic             found_s;

    // Circular priority search; reset suppresses every grant in the same cycle.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s  = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            hit_s   = !found_s && req[cand_s];
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
        gnt_any      = found_s & ~rst;
        gnt          = '0;
        gnt[idx_s]   = gnt_any;
        gnt_idx      = gnt_any ? idx_s : '0;
        rr_ptr_d     = gnt_any ? IDX_W'(rr_next(int'(idx_s), N_REQ)) : rr_ptr_q;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ write-back sources.
// Define REGFILE_WB_PIPE_EN to register addr_rd/data_rd/grant_valid/grant_id.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = regfile_pkg::DATA_WIDTH,
    parameter int LOG2_REGISTERS = regfile_pkg::LOG2_REGISTERS,
    parameter int NUM_REQ        = regfile_pkg::NUM_REQ,
    parameter int LOG2_REQ       = regfile_pkg::LOG2_REQ,
    parameter int CNT_WIDTH      = regfile_pkg::CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*LOG2_REGISTERS-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [LOG2_REGISTERS-1:0]          addr_rd,
    output logic [DATA_WIDTH-1:0]              data_rd,
    output logic                               grant_valid,
    output logic [LOG2_REQ-1:0]                grant_id,
    output logic [CNT_WIDTH-1:0]               conflict_cnt
);

    logic [NUM_REQ-1:0]        gnt_s;
    logic [LOG2_REQ-1:0]       gnt_idx_s;
    logic                      gnt_any_s;
    logic [LOG2_REGISTERS-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0]     wr_data_s;
    logic [LOG2_REQ:0]         pop_s;
    logic [CNT_WIDTH-1:0]      conflict_cnt_q;
    logic [CNT_WIDTH-1:0]      conflict_cnt_d;

    rr_arbiter #(
        .N_REQ (NUM_REQ),
        .IDX_W (LOG2_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    assign req_ready = gnt_s;

    // Winner's address/data onto the write port; idle drives x0 so the write is discarded.
    always_comb begin
        wr_addr_s = '0;
        wr_data_s = '0;
        if (gnt_any_s) begin
            wr_addr_s = req_addr[int'(gnt_idx_s)*LOG2_REGISTERS +: LOG2_REGISTERS];
            wr_data_s = req_data[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wr_addr_s = '0;
            wr_data_s = '0;
        end
    end

    // Saturating count of cycles with two or more requesters competing.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_s = pop_s + (LOG2_REQ+1)'(req_valid[i]);
        end
        conflict_cnt_d = ((pop_s >= (LOG2_REQ+1)'(2)) && (conflict_cnt_q != {CNT_WIDTH{1'b1}}))
                       ? conflict_cnt_q + CNT_WIDTH'(1) : conflict_cnt_q;
    end

    // Conflict statistics register.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

`ifdef REGFILE_WB_PIPE_EN
    logic [LOG2_REGISTERS-1:0] addr_rd_q;
    logic [LOG2_REGISTERS-1:0] addr_rd_d;
    logic [DATA_WIDTH-1:0]     data_rd_q;
    logic [DATA_WIDTH-1:0]     data_rd_d;
    logic                      grant_valid_q;
    logic                      grant_valid_d;
    logic [LOG2_REQ-1:0]       grant_id_q;
    logic [LOG2_REQ-1:0]       grant_id_d;

    // Next write-port contents come straight from the grant mux.
    always_comb begin
        addr_rd_d     = wr_addr_s;
        data_rd_d     = wr_data_s;
        grant_valid_d = gnt_any_s;
        grant_id_d    = gnt_idx_s;
    end

    // One-cycle write-port register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_rd_q     <= '0;
            data_rd_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            addr_rd_q     <= addr_rd_d;
            data_rd_q     <= data_rd_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign addr_rd     = addr_rd_q;
    assign data_rd     = data_rd_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`else
    assign addr_rd     = wr_addr_s;
    assign data_rd     = wr_data_s;
    assign grant_valid = gnt_any_s;
    assign grant_id    = gnt_idx_s;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-level reference model.
// Handles both the default build and REGFILE_WB_PIPE_EN.
module tb_regfile_wb_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [4:0]   addr_rd;
    logic [31:0]  data_rd;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [15:0]  conflict_cnt;

    logic [3:0]   s_ready;
    logic [4:0]   s_addr;
    logic [31:0]  s_data;
    logic         s_gv;
    logic [1:0]   s_gid;
    logic [3:0]   cnt4;

    int n_cmp;
    int n_fail;

    int          m_ptr;
    int          m_cnt;
    int          m_cnt4;
    logic [4:0]  m_pa;
    logic [31:0] m_pd;
    logic        m_pv;
    int          m_pid;

    logic [3:0]  o_ready;
    logic [4:0]  o_addr;
    logic [31:0] o_data;
    logic        o_gv;
    logic [1:0]  o_gid;
    logic [15:0] o_cnt;
    logic [3:0]  o_cnt4;

    int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .addr_rd      (addr_rd),
        .data_rd      (data_rd),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    regfile_wb_arbiter #(.CNT_WIDTH(4)) dut_c4 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (s_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .addr_rd      (s_addr),
        .data_rd      (s_data),
        .grant_valid  (s_gv),
        .grant_id     (s_gid),
        .conflict_cnt (cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Reference model: compare outputs, then advance model state across the coming edge.
    task automatic check();
        int win;
        int c;
        int pop;
        logic [3:0]  er;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ev;
        int          eid;
        win = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (win < 0 && req_valid[c[1:0]]) win = c;
            end
        end
        if (win >= 0) begin
            er  = 4'b0001 << win;
            ea  = req_addr[win*AW +: AW];
            ed  = req_data[win*DW +: DW];
            ev  = 1'b1;
            eid = win;
        end else begin
            er  = 4'b0000;
            ea  = 5'd0;
            ed  = 32'd0;
            ev  = 1'b0;
            eid = 0;
        end
        o_ready = req_ready; o_addr = addr_rd; o_data = data_rd; o_gv = grant_valid;
        o_gid = grant_id; o_cnt = conflict_cnt; o_cnt4 = cnt4;
        chk("ready", req_ready, er);
`ifdef REGFILE_WB_PIPE_EN
        chk("addr_rd", addr_rd, m_pa);
        chk("data_rd", data_rd, m_pd);
        chk("grant_valid", grant_valid, m_pv);
        chk("grant_id", grant_id, m_pid);
`else
        chk("addr_rd", addr_rd, ea);
        chk("data_rd", data_rd, ed);
        chk("grant_valid", grant_valid, ev);
        chk("grant_id", grant_id, eid);
`endif
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("conflict_cnt4", cnt4, m_cnt4);
        pop = $countones(req_valid);
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
            m_pa = 5'd0; m_pd = 32'd0; m_pv = 1'b0; m_pid = 0;
        end else begin
            if (win >= 0) m_ptr = (win + 1) % NR;
            if (pop >= 2) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            end
            m_pa = ea; m_pd = ed; m_pv = ev; m_pid = eid;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v);
        rst = r;
        req_valid = v;
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
        m_pa = 5'd0; m_pd = 32'd0; m_pv = 1'b0; m_pid = 0;
        rst = 1'b1; req_valid = 4'hF; req_addr = 20'd0; req_data = 128'd0;
        repeat (2) @(posedge clk);
        #1;

        // reset with all requesters valid
        step(1'b1, 4'hF);
        chk("rst_ready", o_ready, 32'h0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_gv", o_gv, 32'h0);
        chk("rst_cnt", o_cnt, 32'h0);

        // single request from requester 2
        set_req(2, 5'd5, 32'hDEADBEEF);
        step(1'b0, 4'b0100);
        chk("single_ready", o_ready, 32'h4);
`ifdef REGFILE_WB_PIPE_EN
        step(1'b0, 4'b0000);
`endif
        chk("single_addr", o_addr, 32'd5);
        chk("single_data", o_data, 32'hDEADBEEF);
        chk("single_gid", o_gid, 32'd2);
        chk("single_gv", o_gv, 32'd1);
        step(1'b0, 4'b0000);
        chk("idle_addr", o_addr, 32'd0);
        chk("idle_data", o_data, 32'd0);
        chk("idle_gv", o_gv, 32'd0);
        step(1'b0, 4'hF);
        chk("ptr_after_idle", o_ready, 32'h8);

        // drop without transfer, addr 0 write, same destination twice
        set_req(0, 5'd1, 32'h11111111);
        set_req(1, 5'd2, 32'h22222222);
        set_req(3, 5'd0, 32'hAAAA5555);
        step(1'b0, 4'b0110);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b1000);
        set_req(0, 5'd9, 32'h00000111);
        set_req(1, 5'd9, 32'h00000222);
        step(1'b0, 4'b0011);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);

        // reset in the middle of a burst
        step(1'b0, 4'hF);
        step(1'b1, 4'hF);
        chk("midrst_ready", o_ready, 32'h0);
        step(1'b0, 4'hF);
        chk("after_rst_ready", o_ready, 32'h1);

        // all four held for eight cycles from rr_ptr = 0
        step(1'b1, 4'h0);
        for (int i = 0; i < 8; i++) begin
            set_req(i % NR, 5'(i + 3), 32'hC0DE0000 + 32'(i));
            step(1'b0, 4'hF);
            chk("rr_seq", o_ready, 32'h1 << exp_seq[i]);
        end
        step(1'b0, 4'h0);
        chk("cnt_after_8", o_cnt, 32'd8);

        // saturation of the 4-bit counter
        step(1'b1, 4'h0);
        repeat (20) step(1'b0, 4'hF);
        step(1'b0, 4'h0);
        chk("cnt4_sat", o_cnt4, 32'd15);
        chk("cnt16_20", o_cnt, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
